// File: rtl/trap_ctrl_pkg.sv
// Shared encodings for the machine-mode trap sequencer: instruction patterns,
// CSR addresses, trap causes and sequencer states.
package trap_ctrl_pkg;

   localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
   localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
   localparam logic [31:0] INST_MRET   = 32'h3020_0073;

   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MSTATUS = 12'h300;

   localparam logic [31:0] CAUSE_ECALL    = 32'd11;
   localparam logic [31:0] CAUSE_EBREAK   = 32'd3;
   localparam logic [31:0] CAUSE_TIMER    = 32'h8000_0007;
   localparam logic [31:0] CAUSE_EXT_BASE = 32'h8000_0010;

   localparam logic HoldEnable = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      W_MEPC,
      W_MCAUSE,
      W_MSTATUS,
      W_MSTATUS_MRET,
      ASSERT
   } trap_state_e;

endpackage

// File: rtl/trap_irq_prio.sv
// Lowest-set-bit priority encoder turning the interrupt request lines into
// an mcause value (bit0 is the timer and maps to the standard timer cause).
module trap_irq_prio
   import trap_ctrl_pkg::*;
#(
   parameter int IRQ_W  = 8,
   parameter int ADDR_W = 32
) (
   input  logic [IRQ_W-1:0]  int_flag_i,
   output logic [ADDR_W-1:0] cause_o
);

   localparam int IDX_W = (IRQ_W > 1) ? $clog2(IRQ_W) : 1;

   logic [IDX_W-1:0] idx;

   // Scanning downward lets the lowest set bit overwrite any higher one.
   always_comb begin
      idx = '0;
      for (int i = IRQ_W - 1; i >= 0; i--) begin
         if (int_flag_i[i]) idx = IDX_W'(i);
      end
   end

   assign cause_o = int_flag_i[0] ? ADDR_W'(CAUSE_TIMER)
                                  : ADDR_W'(CAUSE_EXT_BASE) + ADDR_W'(idx);

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: holds the pipeline, writes mepc/mcause/mstatus,
// then pulses a redirect. Define TRAP_VECTORED_EN for vectored interrupt targets.
module trap_ctrl
   import trap_ctrl_pkg::*;
#(
   parameter int IRQ_W  = 8,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       inst_i,
   input  logic [ADDR_W-1:0] inst_addr_i,
   input  logic              jump_flag_i,
   input  logic [ADDR_W-1:0] jump_addr_i,
   input  logic              div_started_i,
   input  logic [IRQ_W-1:0]  int_flag_i,
   input  logic              global_int_en_i,
   input  logic [ADDR_W-1:0] csr_mtvec_i,
   input  logic [ADDR_W-1:0] csr_mepc_i,
   input  logic [ADDR_W-1:0] csr_mstatus_i,
   output logic              hold_flag_o,
   output logic              we_o,
   output logic [11:0]       waddr_o,
   output logic [ADDR_W-1:0] data_o,
   output logic              int_assert_o,
   output logic [ADDR_W-1:0] int_addr_o
);

   trap_state_e       state_q, state_d;
   logic [ADDR_W-1:0] cause_q, cause_d;
   logic [ADDR_W-1:0] ret_q, ret_d;
   logic [ADDR_W-1:0] int_addr_q, int_addr_d;
   logic [ADDR_W-1:0] irq_cause;
   logic [ADDR_W-1:0] trap_target;
   logic              irq_pend;

   function automatic logic [ADDR_W-1:0] trap_mstatus(input logic [ADDR_W-1:0] ms);
      logic [ADDR_W-1:0] r;
      r    = ms;
      r[7] = ms[3];
      r[3] = 1'b0;
      return r;
   endfunction

   function automatic logic [ADDR_W-1:0] mret_mstatus(input logic [ADDR_W-1:0] ms);
      logic [ADDR_W-1:0] r;
      r    = ms;
      r[3] = ms[7];
      r[7] = 1'b1;
      return r;
   endfunction

   trap_irq_prio #(
      .IRQ_W  (IRQ_W),
      .ADDR_W (ADDR_W)
   ) u_prio (
      .int_flag_i (int_flag_i),
      .cause_o    (irq_cause)
   );

   assign irq_pend = (|int_flag_i) && global_int_en_i && !div_started_i;

   // Interrupt causes carry the MSB, so the latched cause also tells ASYNC from SYNC.
`ifdef TRAP_VECTORED_EN
   assign trap_target = (cause_q[ADDR_W-1] && (csr_mtvec_i[1:0] == 2'b01))
                      ? (csr_mtvec_i & ~ADDR_W'(3)) + ADDR_W'({cause_q[4:0], 2'b00})
                      : (csr_mtvec_i & ~ADDR_W'(3));
`else
   assign trap_target = csr_mtvec_i & ~ADDR_W'(3);
`endif

   always_comb begin
      state_d      = state_q;
      cause_d      = cause_q;
      ret_d        = ret_q;
      int_addr_d   = int_addr_q;
      hold_flag_o  = 1'b0;
      we_o         = 1'b0;
      waddr_o      = '0;
      data_o       = '0;
      int_assert_o = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (inst_i == INST_ECALL) begin
               state_d     = W_MEPC;
               cause_d     = ADDR_W'(CAUSE_ECALL);
               ret_d       = inst_addr_i;
               hold_flag_o = HoldEnable;
            end else if (inst_i == INST_EBREAK) begin
               state_d     = W_MEPC;
               cause_d     = ADDR_W'(CAUSE_EBREAK);
               ret_d       = inst_addr_i;
               hold_flag_o = HoldEnable;
            end else if (irq_pend) begin
               state_d     = W_MEPC;
               cause_d     = irq_cause;
               ret_d       = jump_flag_i ? jump_addr_i : inst_addr_i;
               hold_flag_o = HoldEnable;
            end else if (inst_i == INST_MRET) begin
               state_d     = W_MSTATUS_MRET;
               hold_flag_o = HoldEnable;
            end
         end
         W_MEPC: begin
            hold_flag_o = HoldEnable;
            we_o        = 1'b1;
            waddr_o     = CSR_MEPC;
            data_o      = ret_q;
            state_d     = W_MCAUSE;
         end
         W_MCAUSE: begin
            hold_flag_o = HoldEnable;
            we_o        = 1'b1;
            waddr_o     = CSR_MCAUSE;
            data_o      = cause_q;
            state_d     = W_MSTATUS;
         end
         W_MSTATUS: begin
            hold_flag_o = HoldEnable;
            we_o        = 1'b1;
            waddr_o     = CSR_MSTATUS;
            data_o      = trap_mstatus(csr_mstatus_i);
            int_addr_d  = trap_target;
            state_d     = ASSERT;
         end
         W_MSTATUS_MRET: begin
            hold_flag_o = HoldEnable;
            we_o        = 1'b1;
            waddr_o     = CSR_MSTATUS;
            data_o      = mret_mstatus(csr_mstatus_i);
            int_addr_d  = csr_mepc_i;
            state_d     = ASSERT;
         end
         ASSERT: begin
            hold_flag_o  = HoldEnable;
            int_assert_o = 1'b1;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign int_addr_o = int_addr_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         cause_q    <= '0;
         ret_q      <= '0;
         int_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         cause_q    <= cause_d;
         ret_q      <= ret_d;
         int_addr_q <= int_addr_d;
      end
   end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: trap, interrupt, deferral, MRET and reset abort
// sequences with hand-computed CSR writes and redirect targets.
module tb_trap_ctrl;

   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam logic [31:0] ECALL  = 32'h0000_0073;
   localparam logic [31:0] EBREAK = 32'h0010_0073;
   localparam logic [31:0] MRET   = 32'h3020_0073;

   logic        clk;
   logic        rst;
   logic [31:0] inst_i;
   logic [31:0] inst_addr_i;
   logic        jump_flag_i;
   logic [31:0] jump_addr_i;
   logic        div_started_i;
   logic [7:0]  int_flag_i;
   logic        global_int_en_i;
   logic [31:0] csr_mtvec_i;
   logic [31:0] csr_mepc_i;
   logic [31:0] csr_mstatus_i;
   logic        hold_flag_o;
   logic        we_o;
   logic [11:0] waddr_o;
   logic [31:0] data_o;
   logic        int_assert_o;
   logic [31:0] int_addr_o;

   int n_chk  = 0;
   int n_pass = 0;

   trap_ctrl #(.IRQ_W(8), .ADDR_W(32)) dut (
      .clk             (clk),
      .rst             (rst),
      .inst_i          (inst_i),
      .inst_addr_i     (inst_addr_i),
      .jump_flag_i     (jump_flag_i),
      .jump_addr_i     (jump_addr_i),
      .div_started_i   (div_started_i),
      .int_flag_i      (int_flag_i),
      .global_int_en_i (global_int_en_i),
      .csr_mtvec_i     (csr_mtvec_i),
      .csr_mepc_i      (csr_mepc_i),
      .csr_mstatus_i   (csr_mstatus_i),
      .hold_flag_o     (hold_flag_o),
      .we_o            (we_o),
      .waddr_o         (waddr_o),
      .data_o          (data_o),
      .int_assert_o    (int_assert_o),
      .int_addr_o      (int_addr_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Call in the detect cycle with inputs already settled.
   task automatic run_trap(input string tag, input logic [31:0] ret, input logic [31:0] cause,
                           input logic [31:0] ms_exp, input logic [31:0] tgt,
                           input logic [7:0] irq_after, input logic mie_after);
      chk({tag, "_det_hold"}, 32'(hold_flag_o), 32'd1);
      chk({tag, "_det_we"}, 32'(we_o), 32'd0);
      tick();
      inst_i          = NOP;
      int_flag_i      = irq_after;
      global_int_en_i = mie_after;
      #1;
      chk({tag, "_c1_hold"}, 32'(hold_flag_o), 32'd1);
      chk({tag, "_mepc_we"}, 32'(we_o), 32'd1);
      chk({tag, "_mepc_addr"}, 32'(waddr_o), 32'h341);
      chk({tag, "_mepc_data"}, data_o, ret);
      tick();
      chk({tag, "_c2_hold"}, 32'(hold_flag_o), 32'd1);
      chk({tag, "_mcause_addr"}, 32'(waddr_o), 32'h342);
      chk({tag, "_mcause_data"}, data_o, cause);
      tick();
      chk({tag, "_c3_hold"}, 32'(hold_flag_o), 32'd1);
      chk({tag, "_mstatus_addr"}, 32'(waddr_o), 32'h300);
      chk({tag, "_mstatus_data"}, data_o, ms_exp);
      chk({tag, "_c3_assert"}, 32'(int_assert_o), 32'd0);
      tick();
      chk({tag, "_assert"}, 32'(int_assert_o), 32'd1);
      chk({tag, "_target"}, int_addr_o, tgt);
      chk({tag, "_assert_we"}, 32'(we_o), 32'd0);
      tick();
      chk({tag, "_post_assert"}, 32'(int_assert_o), 32'd0);
      chk({tag, "_post_hold"}, 32'(hold_flag_o), 32'd0);
   endtask

   initial begin
      rst             = 1'b0;
      inst_i          = NOP;
      inst_addr_i     = 32'h0;
      jump_flag_i     = 1'b0;
      jump_addr_i     = 32'h0;
      div_started_i   = 1'b0;
      int_flag_i      = 8'h00;
      global_int_en_i = 1'b0;
      csr_mtvec_i     = 32'h400;
      csr_mepc_i      = 32'h0;
      csr_mstatus_i   = 32'h8;
      #1;
      chk("rst_hold", 32'(hold_flag_o), 32'd0);
      chk("rst_we", 32'(we_o), 32'd0);
      chk("rst_assert", 32'(int_assert_o), 32'd0);
      chk("rst_addr", int_addr_o, 32'd0);
      tick();
      tick();
      rst = 1'b1;
      tick();
      chk("idle_hold", 32'(hold_flag_o), 32'd0);

      // ECALL at 0x100
      inst_i      = ECALL;
      inst_addr_i = 32'h100;
      #1;
      run_trap("ecall", 32'h100, 32'd11, 32'h80, 32'h400, 8'h00, 1'b0);

      // External irq line 2 while EX redirects
      inst_addr_i     = 32'h180;
      jump_flag_i     = 1'b1;
      jump_addr_i     = 32'h200;
      int_flag_i      = 8'h04;
      global_int_en_i = 1'b1;
      #1;
      run_trap("irq2", 32'h200, 32'h8000_0012, 32'h80, 32'h400, 8'h02, 1'b0);
      jump_flag_i = 1'b0;

      // Timer irq deferred by an in-flight divide
      inst_addr_i     = 32'h300;
      int_flag_i      = 8'h01;
      global_int_en_i = 1'b1;
      div_started_i   = 1'b1;
      #1;
      for (int i = 0; i < 5; i++) begin
         chk("div_hold", 32'(hold_flag_o), 32'd0);
         chk("div_we", 32'(we_o), 32'd0);
         tick();
      end
      div_started_i = 1'b0;
      #1;
      run_trap("div_irq", 32'h300, 32'h8000_0007, 32'h80, 32'h400, 8'h00, 1'b0);

      // MRET
      inst_i        = MRET;
      csr_mstatus_i = 32'h80;
      csr_mepc_i    = 32'h104;
      #1;
      chk("mret_det_hold", 32'(hold_flag_o), 32'd1);
      tick();
      inst_i = NOP;
      #1;
      chk("mret_we", 32'(we_o), 32'd1);
      chk("mret_waddr", 32'(waddr_o), 32'h300);
      chk("mret_data", data_o, 32'h88);
      tick();
      chk("mret_assert", 32'(int_assert_o), 32'd1);
      chk("mret_target", int_addr_o, 32'h104);
      tick();
      chk("mret_post_assert", 32'(int_assert_o), 32'd0);
      chk("mret_addr_held", int_addr_o, 32'h104);

      // ECALL and timer irq together: ECALL wins, irq masked once MIE drops
      csr_mstatus_i   = 32'h8;
      inst_i          = ECALL;
      inst_addr_i     = 32'h140;
      int_flag_i      = 8'h01;
      global_int_en_i = 1'b1;
      #1;
      run_trap("ecall_irq", 32'h140, 32'd11, 32'h80, 32'h400, 8'h01, 1'b0);
      for (int i = 0; i < 3; i++) begin
         chk("masked_hold", 32'(hold_flag_o), 32'd0);
         tick();
      end
      int_flag_i = 8'h00;

      // EBREAK with mtvec mode bits set: sync traps use the base
      csr_mtvec_i   = 32'h401;
      csr_mstatus_i = 32'h0;
      inst_i        = EBREAK;
      inst_addr_i   = 32'h208;
      #1;
      run_trap("ebreak", 32'h208, 32'd3, 32'h0, 32'h400, 8'h00, 1'b0);

      // Timer irq with mtvec mode 1
      csr_mstatus_i   = 32'h8;
      inst_addr_i     = 32'h500;
      int_flag_i      = 8'h01;
      global_int_en_i = 1'b1;
      #1;
`ifdef TRAP_VECTORED_EN
      run_trap("vec_timer", 32'h500, 32'h8000_0007, 32'h80, 32'h41C, 8'h00, 1'b0);
`else
      run_trap("vec_timer", 32'h500, 32'h8000_0007, 32'h80, 32'h400, 8'h00, 1'b0);
`endif
      csr_mtvec_i = 32'h400;

      // Reset asserted during the mcause write aborts the sequence
      inst_i      = ECALL;
      inst_addr_i = 32'h600;
      #1;
      tick();
      inst_i = NOP;
      tick();
      chk("abort_pre_waddr", 32'(waddr_o), 32'h342);
      rst = 1'b0;
      #1;
      chk("abort_hold", 32'(hold_flag_o), 32'd0);
      chk("abort_we", 32'(we_o), 32'd0);
      chk("abort_waddr", 32'(waddr_o), 32'd0);
      chk("abort_data", data_o, 32'd0);
      chk("abort_assert", 32'(int_assert_o), 32'd0);
      chk("abort_addr", int_addr_o, 32'd0);
      tick();
      rst = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         chk("abort_idle_hold", 32'(hold_flag_o), 32'd0);
         chk("abort_idle_we", 32'(we_o), 32'd0);
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
